// File: rtl/nco_pkg.sv
// Phase-format constants, CORDIC arctangent table generator and FSM state type shared by the
// NCO and phase-detector CORDIC blocks.
package nco_pkg;

   localparam int  NCO_PHASE_WIDTH = 12;
   localparam int  PI_PHASE        = 2 ** (NCO_PHASE_WIDTH - 1);
   localparam int  HALF_PI_PHASE   = 2 ** (NCO_PHASE_WIDTH - 2);
   localparam real PI_REAL         = 3.14159265358979323846;

   typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

   function automatic int half_pi_phase(input int pw);
      return 2 ** (pw - 2);
   endfunction

   // round(atan(2^-k) / pi * 2^(pw-1)); only ever evaluated at elaboration
   function automatic int atan_entry(input int k, input int pw);
      real val;
      val = $atan(1.0 / (2.0 ** k)) / PI_REAL * (2.0 ** (pw - 1));
      return $rtoi(val + 0.5);
   endfunction

endpackage

// File: rtl/cordic_quadrant_fold.sv
// Combinational pre-rotation that folds any I/Q sample into the right half-plane (x >= 0) so the
// vectoring CORDIC only has to cover +/-pi/2.
module cordic_quadrant_fold
   import nco_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int PHASE_WIDTH = 12
) (
   input  logic [DATA_WIDTH-1:0]  i_i,
   input  logic [DATA_WIDTH-1:0]  i_q,
   output logic [DATA_WIDTH+1:0]  o_x,
   output logic [DATA_WIDTH+1:0]  o_y,
   output logic [PHASE_WIDTH+1:0] o_z
);

   localparam int XW = DATA_WIDTH + 2;
   localparam int ZW = PHASE_WIDTH + 2;
   localparam logic [ZW-1:0] HALF_PI = ZW'(half_pi_phase(PHASE_WIDTH));

   logic [XW-1:0] w_i;
   logic [XW-1:0] w_q;

   // Two guard bits so negating the most negative sample cannot overflow
   assign w_i = {{2{i_i[DATA_WIDTH-1]}}, i_i};
   assign w_q = {{2{i_q[DATA_WIDTH-1]}}, i_q};

   always_comb begin
      o_x = w_i;
      o_y = w_q;
      o_z = '0;
      if (w_i[XW-1]) begin
         if (!w_q[XW-1]) begin
            o_x = w_q;
            o_y = -w_i;
            o_z = HALF_PI;
         end else begin
            o_x = -w_q;
            o_y = w_i;
            o_z = -HALF_PI;
         end
      end
   end

endmodule

// File: rtl/cordic_phase_detector.sv
// Iterative vectoring-mode CORDIC: returns phase and gain-scaled magnitude of one I/Q sample,
// one micro-rotation per clock, with valid/ready handshakes on both sides.
module cordic_phase_detector
   import nco_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int PHASE_WIDTH = 12,
   parameter int ITER        = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DATA_WIDTH-1:0]  i_i,
   input  logic [DATA_WIDTH-1:0]  q_i,
   input  logic                   valid_i,
   output logic                   ready_o,
   output logic [PHASE_WIDTH-1:0] phase_o,
   output logic [DATA_WIDTH+1:0]  mag_o,
   output logic                   valid_o,
   input  logic                   ready_i
);

   localparam int XW = DATA_WIDTH + 2;
   localparam int ZW = PHASE_WIDTH + 2;
   localparam int IW = $clog2(ITER);

   state_t               r_state;
   state_t               w_state_next;
   logic [IW-1:0]        r_iter;
   logic signed [XW-1:0] r_x;
   logic signed [XW-1:0] r_y;
   logic signed [ZW-1:0] r_z;
   logic                 r_zero;

   logic [XW-1:0]        w_fold_x;
   logic [XW-1:0]        w_fold_y;
   logic [ZW-1:0]        w_fold_z;
   logic signed [XW-1:0] w_x_sh;
   logic signed [XW-1:0] w_y_sh;
   logic signed [XW-1:0] w_x_next;
   logic signed [XW-1:0] w_y_next;
   logic signed [ZW-1:0] w_z_next;
   logic [ZW-1:0]        w_atan [2**IW];
   logic                 w_accept;
   logic                 w_unused_z;

   for (genvar k = 0; k < 2 ** IW; k++) begin : g_atan
      if (k < ITER) begin : g_val
         localparam int ATAN_VAL = atan_entry(k, PHASE_WIDTH);
         assign w_atan[k] = ZW'(ATAN_VAL);
      end else begin : g_pad
         assign w_atan[k] = '0;
      end
   end

   cordic_quadrant_fold #(
      .DATA_WIDTH  (DATA_WIDTH),
      .PHASE_WIDTH (PHASE_WIDTH)
   ) u_fold (
      .i_i (i_i),
      .i_q (q_i),
      .o_x (w_fold_x),
      .o_y (w_fold_y),
      .o_z (w_fold_z)
   );

   assign w_accept = (r_state == IDLE) && valid_i;

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:    if (valid_i) w_state_next = ROT;
         ROT:     if (r_iter == IW'(ITER - 1)) w_state_next = DONE;
         DONE:    if (ready_i) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_x_sh = r_x >>> r_iter;
      w_y_sh = r_y >>> r_iter;
      if (!r_y[XW-1]) begin
         w_x_next = r_x + w_y_sh;
         w_y_next = r_y - w_x_sh;
         w_z_next = r_z + $signed(w_atan[r_iter]);
      end else begin
         w_x_next = r_x - w_y_sh;
         w_y_next = r_y + w_x_sh;
         w_z_next = r_z - $signed(w_atan[r_iter]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_iter <= '0;
         r_x    <= '0;
         r_y    <= '0;
         r_z    <= '0;
         r_zero <= 1'b0;
      end else if (w_accept) begin
         r_iter <= '0;
         r_x    <= w_fold_x;
         r_y    <= w_fold_y;
         r_z    <= w_fold_z;
         r_zero <= (i_i == '0) && (q_i == '0);
      end else if (r_state == ROT) begin
         r_iter <= r_iter + 1'b1;
         r_x    <= w_x_next;
         r_y    <= w_y_next;
         r_z    <= w_z_next;
      end
   end

   // A zero vector has no defined angle; the rotations would still accumulate atan terms
   assign phase_o    = r_zero ? '0 : r_z[PHASE_WIDTH-1:0];
   assign mag_o      = r_x;
   assign valid_o    = (r_state == DONE);
   assign ready_o    = (r_state == IDLE) && !rst;
   assign w_unused_z = ^r_z[ZW-1:PHASE_WIDTH];

endmodule

// File: tb/tb_cordic_phase_detector.sv
// Directed self-checking bench for cordic_phase_detector with hand-computed phase/magnitude values.
module tb_cordic_phase_detector;

   localparam int DW  = 16;
   localparam int PW  = 12;
   localparam int IT  = 12;
   localparam int A   = 16000;
   localparam int MAG_A = 26349;  // 16000 * K(12 iter)
   localparam int MAG_FS = 53962; // 32768 * K

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] i_i;
   logic [DW-1:0] q_i;
   logic          valid_i;
   logic          ready_o;
   logic [PW-1:0] phase_o;
   logic [DW+1:0] mag_o;
   logic          valid_o;
   logic          ready_i;

   int n_tests = 0;
   int n_fail  = 0;

   cordic_phase_detector #(
      .DATA_WIDTH  (DW),
      .PHASE_WIDTH (PW),
      .ITER        (IT)
   ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .i_i     (i_i),
      .q_i     (q_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .phase_o (phase_o),
      .mag_o   (mag_o),
      .valid_o (valid_o),
      .ready_i (ready_i)
   );

   always #5 clk = ~clk;

   // wrap_bits > 0 compares modulo 2^wrap_bits (phase wraps at +/-pi)
   task automatic check(input string tag, input int obs, input int exp, input int tol,
                        input int wrap_bits);
      int diff;
      n_tests++;
      diff = obs - exp;
      if (wrap_bits > 0) begin
         diff = diff & ((1 << wrap_bits) - 1);
         if (diff >= (1 << (wrap_bits - 1))) diff = diff - (1 << wrap_bits);
      end
      if (diff > tol || diff < -tol) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d (+/-%0d)", tag, obs, exp, tol);
      end
   endtask

   function automatic int ph();
      return int'($signed(phase_o));
   endfunction

   function automatic int mg();
      return int'(mag_o);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offers a sample, returns once valid_o is seen; lat counts the accept cycle inclusive
   task automatic run_sample(input int i, input int q, output int lat);
      int n;
      i_i     = DW'(i);
      q_i     = DW'(q);
      valid_i = 1'b1;
      n = 0;
      while (!ready_o && n < 50) begin
         step();
         n++;
      end
      check("ready_before_accept", int'(ready_o), 1, 0, 0);
      step();
      valid_i = 1'b0;
      lat = 1;
      while (!valid_o && lat < 50) begin
         step();
         lat++;
      end
      check("valid_timeout", int'(valid_o), 1, 0, 0);
   endtask

   initial begin
      int lat;
      int cyc;
      int first_rise;
      int second_rise;
      logic prev_v;

      rst = 1'b1; i_i = '0; q_i = '0; valid_i = 1'b0; ready_i = 1'b1;
      step(); step(); step();
      check("rst_valid_o", int'(valid_o), 0, 0, 0);
      check("rst_ready_o", int'(ready_o), 0, 0, 0);
      check("rst_phase_o", ph(), 0, 0, 0);
      check("rst_mag_o", mg(), 0, 0, 0);
      rst = 1'b0;
      #1;
      check("idle_ready_o", int'(ready_o), 1, 0, 0);

      run_sample(A, 0, lat);
      check("lat_A_0", lat, IT + 1, 0, 0);
      check("ph_A_0", ph(), 0, 2, 0);
      check("mag_A_0", mg(), MAG_A, 4, 0);
      step();
      check("idle_after_xfer", int'(ready_o), 1, 0, 0);
      check("valid_drop_after_xfer", int'(valid_o), 0, 0, 0);

      run_sample(0, A, lat);
      check("ph_0_A", ph(), 1024, 2, 0);
      check("mag_0_A", mg(), MAG_A, 4, 0);
      step();
      run_sample(A, A, lat);
      check("ph_A_A", ph(), 512, 2, 0);
      step();
      run_sample(0, -A, lat);
      check("ph_0_mA", ph(), -1024, 2, 0);
      step();
      run_sample(-A, -A, lat);
      check("ph_mA_mA", ph(), -1536, 2, 0);
      step();
      run_sample(-A, 0, lat);
      check("ph_mA_0", ph(), -2048, 2, PW);
      check("mag_mA_0", mg(), MAG_A, 4, 0);
      step();
      run_sample(-32768, 0, lat);
      check("ph_fs_0", ph(), -2048, 2, PW);
      check("mag_fs_0", mg(), MAG_FS, 4, 0);
      step();
      run_sample(0, 0, lat);
      check("ph_zero", ph(), 0, 0, 0);
      check("mag_zero", mg(), 0, 0, 0);
      step();

      // Downstream stall: result must hold while competing input pulses are ignored
      ready_i = 1'b0;
      run_sample(0, A, lat);
      for (int c = 0; c < 5; c++) begin
         i_i = DW'(A); q_i = '0; valid_i = c[0];
         step();
         check("stall_valid_o", int'(valid_o), 1, 0, 0);
         check("stall_ready_o", int'(ready_o), 0, 0, 0);
         check("stall_phase", ph(), 1024, 2, 0);
         check("stall_mag", mg(), MAG_A, 4, 0);
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      step();
      check("stall_release_valid", int'(valid_o), 0, 0, 0);
      check("stall_release_ready", int'(ready_o), 1, 0, 0);

      // Reset during rotation iteration 6
      i_i = DW'(-A); q_i = DW'(-A); valid_i = 1'b1;
      step();
      valid_i = 1'b0;
      for (int c = 0; c < 6; c++) step();
      rst = 1'b1;
      step();
      check("rot_rst_valid", int'(valid_o), 0, 0, 0);
      rst = 1'b0;
      #1;
      check("rot_rst_ready", int'(ready_o), 1, 0, 0);
      for (int c = 0; c < 8; c++) begin
         step();
         check("rot_rst_no_valid", int'(valid_o), 0, 0, 0);
      end
      run_sample(A, A, lat);
      check("ph_after_rst", ph(), 512, 2, 0);
      check("lat_after_rst", lat, IT + 1, 0, 0);
      step();

      // Back-to-back with valid_i held high: one result every ITER+2 cycles
      i_i = DW'(A); q_i = DW'(A); valid_i = 1'b1;
      prev_v = 1'b0; first_rise = -1; second_rise = -1; cyc = 0;
      while (second_rise < 0 && cyc < 100) begin
         step();
         cyc++;
         if (valid_o && !prev_v) begin
            check("b2b_phase", ph(), 512, 2, 0);
            if (first_rise < 0) first_rise = cyc;
            else second_rise = cyc;
         end
         prev_v = valid_o;
      end
      valid_i = 1'b0;
      check("b2b_period", second_rise - first_rise, IT + 2, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
